// File: rtl/control_unit.sv
// Microsequencer for the 8-bit CPU: a fetch/execute T-state counter with a combinational strobe decode.
// Optional build macro CU_EARLY_END_EN ends each instruction at its last active step.
module control_unit #(
    parameter int         T_STATES = 6,
    parameter logic [1:0] ALU_ADD  = 2'b00,
    parameter logic [1:0] ALU_SUB  = 2'b01
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       prog_en,
    input  logic [3:0] opcode,
    output logic       ir_wr,
    output logic       ir_rd,
    output logic       mar_en,
    output logic       ram_wr,
    output logic       ram_rd,
    output logic       reg_A_wr,
    output logic       reg_A_rd,
    output logic       reg_B_wr,
    output logic       reg_B_rd,
    output logic       alu_en,
    output logic [1:0] alu_sel,
    output logic       PC_cnt_en,
    output logic       PC_out_en,
    output logic       pc_ld,
    output logic       seg7_en,
    output logic       hlt,
    output logic [2:0] step,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam step_t LAST_T = step_t'(3'(T_STATES - 1));

    step_t r_step;
    step_t w_step_nxt;
    logic  r_halted;
    logic  w_halted_nxt;
    logic  w_active;
    logic  w_last;

    always_ff @(posedge clk) begin
        r_step   <= w_step_nxt;
        r_halted <= w_halted_nxt;
    end

    always_comb begin
        w_step_nxt   = r_step;
        w_halted_nxt = r_halted;
        w_active     = !clr && !prog_en && !r_halted;
        w_last       = (r_step == LAST_T);
        ir_wr        = 1'b0;
        ir_rd        = 1'b0;
        mar_en       = 1'b0;
        ram_wr       = 1'b0;
        ram_rd       = 1'b0;
        reg_A_wr     = 1'b0;
        reg_A_rd     = 1'b0;
        reg_B_wr     = 1'b0;
        reg_B_rd     = 1'b0;
        alu_en       = 1'b0;
        alu_sel      = ALU_ADD;
        PC_cnt_en    = 1'b0;
        PC_out_en    = 1'b0;
        pc_ld        = 1'b0;
        seg7_en      = 1'b0;
        instr_done   = 1'b0;
        hlt          = r_halted && !clr;

`ifdef CU_EARLY_END_EN
        // Last active step per opcode; HLT keeps the full-length count and never reaches it.
        case (opcode)
            OP_LDA, OP_STA:                 w_last = (r_step == T4);
            OP_ADD, OP_SUB, OP_HLT:         w_last = (r_step == T5);
            default:                        w_last = (r_step == T3);
        endcase
`endif

        if (clr) begin
            w_step_nxt   = T0;
            w_halted_nxt = 1'b0;
        end else if (!prog_en && !r_halted) begin
            if (r_step == T3 && opcode == OP_HLT)
                w_halted_nxt = 1'b1;
            else if (w_last)
                w_step_nxt = T0;
            else
                w_step_nxt = step_t'(r_step + 3'd1);
        end

        if (w_active) begin
            instr_done = w_last;
            case (r_step)
                T0: begin PC_out_en = 1'b1; mar_en = 1'b1; end
                T1: PC_cnt_en = 1'b1;
                T2: begin ram_rd = 1'b1; ir_wr = 1'b1; end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_rd = 1'b1; mar_en = 1'b1; end
                        OP_LDI: begin ir_rd = 1'b1; reg_A_wr = 1'b1; end
                        OP_JMP: begin ir_rd = 1'b1; pc_ld = 1'b1; end
                        OP_OUT: begin reg_A_rd = 1'b1; seg7_en = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LDA:         begin ram_rd = 1'b1; reg_A_wr = 1'b1; end
                        OP_ADD, OP_SUB: begin ram_rd = 1'b1; reg_B_wr = 1'b1; end
                        OP_STA:         begin reg_A_rd = 1'b1; ram_wr = 1'b1; end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_en   = 1'b1;
                        reg_A_wr = 1'b1;
                        alu_sel  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign step = r_step;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues hand-written per-cycle expectations,
// and a negedge monitor pops and compares them, also checking that at most one bus driver is active.
module tb_control_unit;

    logic       clk;
    logic       clr;
    logic       prog_en;
    logic [3:0] opcode;
    logic       ir_wr, ir_rd, mar_en, ram_wr, ram_rd;
    logic       reg_A_wr, reg_A_rd, reg_B_wr, reg_B_rd;
    logic       alu_en, PC_cnt_en, PC_out_en, pc_ld, seg7_en, hlt, instr_done;
    logic [1:0] alu_sel;
    logic [2:0] step;

    control_unit dut (
        .clk(clk), .clr(clr), .prog_en(prog_en), .opcode(opcode),
        .ir_wr(ir_wr), .ir_rd(ir_rd), .mar_en(mar_en), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .reg_A_wr(reg_A_wr), .reg_A_rd(reg_A_rd), .reg_B_wr(reg_B_wr), .reg_B_rd(reg_B_rd),
        .alu_en(alu_en), .alu_sel(alu_sel), .PC_cnt_en(PC_cnt_en), .PC_out_en(PC_out_en),
        .pc_ld(pc_ld), .seg7_en(seg7_en), .hlt(hlt), .step(step), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CU_EARLY_END_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    localparam logic [13:0] B_IRWR  = 14'h2000;
    localparam logic [13:0] B_IRRD  = 14'h1000;
    localparam logic [13:0] B_MAR   = 14'h0800;
    localparam logic [13:0] B_RAMWR = 14'h0400;
    localparam logic [13:0] B_RAMRD = 14'h0200;
    localparam logic [13:0] B_AWR   = 14'h0100;
    localparam logic [13:0] B_ARD   = 14'h0080;
    localparam logic [13:0] B_BWR   = 14'h0040;
    localparam logic [13:0] B_BRD   = 14'h0020;
    localparam logic [13:0] B_ALU   = 14'h0010;
    localparam logic [13:0] B_PCC   = 14'h0008;
    localparam logic [13:0] B_PCO   = 14'h0004;
    localparam logic [13:0] B_PCLD  = 14'h0002;
    localparam logic [13:0] B_SEG   = 14'h0001;
    localparam logic [13:0] NONE    = 14'h0000;
    localparam logic [13:0] DRIVERS = B_IRRD | B_RAMRD | B_ARD | B_BRD | B_ALU | B_PCO;

    typedef struct packed {
        logic        chk_step;
        logic [2:0]  step;
        logic [13:0] strb;
        logic [1:0]  alu;
        logic        hlt;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [13:0] act;
            e   = q.pop_front();
            act = {ir_wr, ir_rd, mar_en, ram_wr, ram_rd, reg_A_wr, reg_A_rd,
                   reg_B_wr, reg_B_rd, alu_en, PC_cnt_en, PC_out_en, pc_ld, seg7_en};
            if (e.chk_step) check("step", 16'(step), 16'(e.step));
            check("strobes", 16'(act), 16'(e.strb));
            check("alu_sel", 16'(alu_sel), 16'(e.alu));
            check("hlt", 16'(hlt), 16'(e.hlt));
            check("instr_done", 16'(instr_done), 16'(e.done));
            check("bus_onehot", 16'($countones(act & DRIVERS) <= 1), 16'd1);
            cycle++;
        end
    end

    task automatic cyc(input logic c, input logic pe, input logic [3:0] opc, input logic chk,
                       input logic [2:0] s, input logic [13:0] strb, input logic [1:0] alu,
                       input logic h, input logic d);
        exp_t e;
        @(posedge clk);
        #1;
        clr     = c;
        prog_en = pe;
        opcode  = opc;
        e.chk_step = chk;
        e.step     = s;
        e.strb     = strb;
        e.alu      = alu;
        e.hlt      = h;
        e.done     = d;
        q.push_back(e);
    endtask

    // One instruction from step 'first'; 'last' is its final active step in the early-end build.
    task automatic instr(input logic [3:0] opc, input logic [13:0] s3, input logic [13:0] s4,
                         input logic [13:0] s5, input logic [1:0] alu5, input int last,
                         input int first);
        logic [13:0] e[6];
        int L;
        e[0] = B_PCO | B_MAR;
        e[1] = B_PCC;
        e[2] = B_RAMRD | B_IRWR;
        e[3] = s3;
        e[4] = s4;
        e[5] = s5;
        L = EE ? last : 5;
        for (int s = first; s <= L; s++)
            cyc(1'b0, 1'b0, opc, 1'b1, 3'(s), e[s], (s == 5) ? alu5 : 2'b00, 1'b0, s == L);
    endtask

    initial begin
        clr = 1'b1; prog_en = 1'b0; opcode = 4'h0;
        // Reset: first cycle step unknown, second shows step 0.
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 3'd0, NONE, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'd0, NONE, 2'b00, 1'b0, 1'b0);
        instr(4'b0000, B_IRRD | B_MAR, B_RAMRD | B_AWR, NONE, 2'b00, 4, 0);   // LDA
        instr(4'b0001, B_IRRD | B_MAR, B_RAMRD | B_BWR, B_ALU | B_AWR, 2'b00, 5, 0); // ADD
        instr(4'b0010, B_IRRD | B_MAR, B_RAMRD | B_BWR, B_ALU | B_AWR, 2'b01, 5, 0); // SUB
        instr(4'b0100, B_IRRD | B_MAR, B_ARD | B_RAMWR, NONE, 2'b00, 4, 0);   // STA
        instr(4'b0110, B_IRRD | B_PCLD, NONE, NONE, 2'b00, 3, 0);             // JMP
        instr(4'b0101, B_IRRD | B_AWR, NONE, NONE, 2'b00, 3, 0);              // LDI
        instr(4'b1110, B_ARD | B_SEG, NONE, NONE, 2'b00, 3, 0);               // OUT
        instr(4'b0011, NONE, NONE, NONE, 2'b00, 3, 0);                        // NOP
        // clr at T4 of LDA aborts; fetch restarts.
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'd0, B_PCO | B_MAR, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'd1, B_PCC, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'd2, B_RAMRD | B_IRWR, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'd3, B_IRRD | B_MAR, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 3'd4, NONE, 2'b00, 1'b0, 1'b0);
        instr(4'b0000, B_IRRD | B_MAR, B_RAMRD | B_AWR, NONE, 2'b00, 4, 0);
        // prog_en held at T1 for 10 cycles, then PC_cnt_en fires once.
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 3'd0, B_PCO | B_MAR, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 4'h0, 1'b1, 3'd1, NONE, 2'b00, 1'b0, 1'b0);
        instr(4'b0000, B_IRRD | B_MAR, B_RAMRD | B_AWR, NONE, 2'b00, 4, 1);
        // HLT: freeze at T3 with hlt high until clr.
        cyc(1'b0, 1'b0, 4'hF, 1'b1, 3'd0, B_PCO | B_MAR, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, 1'b1, 3'd1, B_PCC, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, 1'b1, 3'd2, B_RAMRD | B_IRWR, 2'b00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'hF, 1'b1, 3'd3, NONE, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b0, 4'hF, 1'b1, 3'd3, NONE, 2'b00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'hF, 1'b1, 3'd3, NONE, 2'b00, 1'b0, 1'b0);
        instr(4'b0101, B_IRRD | B_AWR, NONE, NONE, 2'b00, 3, 0);              // LDI after halt
        instr(4'b1110, B_ARD | B_SEG, NONE, NONE, 2'b00, 3, 0);               // OUT
        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d", cycle);
        $fatal(1, "timeout");
    end

endmodule
